// File: rtl/or1200_keystream_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// or1200_keystream_prefetch_pkg
// Shared definitions for the keystream prefetcher:
//   - controller state encoding (IDLE / ISSUE / WAIT)
//   - l.seed field select codes
//   - keystream mode codes (OFB / CTR)
//   - bit offsets of each field inside the 128-bit seed block
// ---------------------------------------------------------------------------
package or1200_keystream_prefetch_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_OFB = 1'b0,
    MODE_CTR = 1'b1
  } mode_e;

  // Field select codes on seed_sel; codes 5..7 write nothing.
  localparam logic [2:0] SEL_ROW  = 3'd0;
  localparam logic [2:0] SEL_COL  = 3'd1;
  localparam logic [2:0] SEL_TB   = 3'd2;
  localparam logic [2:0] SEL_DB   = 3'd3;
  localparam logic [2:0] SEL_CNTR = 3'd4;

  // Seed block layout: {zero pad, cntr, db, tb, col, row}, row at bit 0.
  localparam int ROW_LSB  = 0;
  localparam int ROW_W    = 32;
  localparam int COL_LSB  = 32;
  localparam int COL_W    = 16;
  localparam int TB_LSB   = 48;
  localparam int TB_W     = 16;
  localparam int DB_LSB   = 64;
  localparam int DB_W     = 8;
  localparam int CNTR_LSB = 72;

endpackage

// File: rtl/or1200_keystream_prefetch_if.sv
// ---------------------------------------------------------------------------
// or1200_keystream_prefetch_if
// Bundles the prefetcher's seed-decode, cipher and LSU pad signals.
//   slave  : the prefetcher's view (drives aes_ld/aes_text_in and the pad side)
//   master : the surrounding core + cipher (drives seeds, control, results)
// Signals:
//   seed_wr/seed_sel/seed_data  l.seed field write
//   start/stop/mode             keystream control, mode sampled on start
//   aes_ld/aes_text_in          cipher load strobe and input block
//   aes_done/aes_text_out       cipher result strobe and block
//   pad_rd                      pop head pad
//   pad_out/pad_valid/pad_level head pad, non-empty flag, occupancy
//   unstall                     low only while running with no pad ready
// ---------------------------------------------------------------------------
interface or1200_keystream_prefetch_if
  import or1200_keystream_prefetch_pkg::*;
#(
  parameter int LVL_W = 3
);
  logic             seed_wr;
  logic [2:0]       seed_sel;
  logic [31:0]      seed_data;
  logic             start;
  logic             stop;
  logic             mode;
  logic             aes_ld;
  logic [BLK_W-1:0] aes_text_in;
  logic             aes_done;
  logic [BLK_W-1:0] aes_text_out;
  logic             pad_rd;
  logic [BLK_W-1:0] pad_out;
  logic             pad_valid;
  logic [LVL_W-1:0] pad_level;
  logic             unstall;

  modport slave (
    input  seed_wr, seed_sel, seed_data, start, stop, mode,
    input  aes_done, aes_text_out, pad_rd,
    output aes_ld, aes_text_in, pad_out, pad_valid, pad_level, unstall
  );

  modport master (
    output seed_wr, seed_sel, seed_data, start, stop, mode,
    output aes_done, aes_text_out, pad_rd,
    input  aes_ld, aes_text_in, pad_out, pad_valid, pad_level, unstall
  );
endinterface

// File: rtl/or1200_pad_fifo.sv
// ---------------------------------------------------------------------------
// or1200_pad_fifo
// DEPTH x 128-bit keystream pad FIFO with show-ahead head output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push/i_data write one pad (ignored when full)
//   i_pop         remove head pad (ignored when empty)
//   i_flush       empty the FIFO; wins over push and pop
//   o_head        current head pad (meaningful when o_valid)
//   o_valid       non-empty
//   o_full        level == DEPTH
//   o_level       occupancy
//   o_level_nxt   occupancy after this clock edge
// ---------------------------------------------------------------------------
module or1200_pad_fifo
  import or1200_keystream_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [BLK_W-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [BLK_W-1:0] o_head,
  output logic             o_valid,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level,
  output logic [LVL_W-1:0] o_level_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [BLK_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_valid = (r_level != '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && o_valid && !i_flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    o_level_nxt = r_level;
    if (i_flush)
      o_level_nxt = '0;
    else if (w_push && !w_pop)
      o_level_nxt = r_level + 1'b1;
    else if (w_pop && !w_push)
      o_level_nxt = r_level - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_level <= '0;
    else     r_level <= o_level_nxt;
  end

  // NOTE: storage is not reset; its content is never observed unless the level says it was written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/or1200_keystream_prefetch.sv
// ---------------------------------------------------------------------------
// or1200_keystream_prefetch
// Collects l.seed fields, drives an external 128-bit cipher through an
// aes_ld / aes_done handshake and prefetches up to DEPTH keystream pads
// (OFB or CTR) so the LSU XOR path can pop a ready pad.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       or1200_keystream_prefetch_if.slave (seed, control, cipher, pad)
// At most one cipher operation is outstanding. A result that belongs to an
// aborted keystream (start/stop while in flight) is dropped via r_discard.
// ---------------------------------------------------------------------------
module or1200_keystream_prefetch
  import or1200_keystream_prefetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CNTR_W = 16,
  parameter int LVL_W  = 3
)(
  input  logic clk,
  input  logic rst,
  or1200_keystream_prefetch_if.slave bus
);

  // Seed fields as written by l.seed.
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [TB_W-1:0]   r_tb;
  logic [DB_W-1:0]   r_db;
  logic [CNTR_W-1:0] r_cntr;

  state_e           r_state;
  mode_e            r_mode;
  logic             r_discard;
  logic             r_aes_ld;
  logic             r_unstall;
  logic [BLK_W-1:0] r_aes_text_in;
  logic [BLK_W-1:0] r_work;   // seed of the running keystream (CTR counter advances here)
  logic [BLK_W-1:0] r_next;   // block to feed the cipher at the next issue

  logic [BLK_W-1:0] w_seed;
  logic [BLK_W-1:0] w_work_inc;
  logic [BLK_W-1:0] w_head;
  logic             w_valid;
  logic             w_full;
  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_inflight;
  logic             w_flush;
  logic             w_push;
  logic             w_idle_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_tb   <= '0;
      r_db   <= '0;
      r_cntr <= '0;
    end else if (bus.seed_wr) begin
      case (bus.seed_sel)
        SEL_ROW:  r_row  <= bus.seed_data;
        SEL_COL:  r_col  <= bus.seed_data[COL_W-1:0];
        SEL_TB:   r_tb   <= bus.seed_data[TB_W-1:0];
        SEL_DB:   r_db   <= bus.seed_data[DB_W-1:0];
        SEL_CNTR: r_cntr <= CNTR_W'(bus.seed_data);
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_seed = '0;
    w_seed[ROW_LSB  +: ROW_W]  = r_row;
    w_seed[COL_LSB  +: COL_W]  = r_col;
    w_seed[TB_LSB   +: TB_W]   = r_tb;
    w_seed[DB_LSB   +: DB_W]   = r_db;
    w_seed[CNTR_LSB +: CNTR_W] = r_cntr;
  end

  // CTR successor: only the counter field moves, wrapping modulo 2^CNTR_W.
  always_comb begin
    w_work_inc = r_work;
    w_work_inc[CNTR_LSB +: CNTR_W] = r_work[CNTR_LSB +: CNTR_W] + 1'b1;
  end

  // An op is still pending after this edge unless its result arrives now.
  assign w_inflight = ((r_state == ST_WAIT) || r_discard) && !bus.aes_done;
  assign w_flush    = bus.start || bus.stop;
  assign w_push     = (r_state == ST_WAIT) && bus.aes_done && !r_discard && !w_flush;
  // Only stop enters IDLE; start always leaves it.
  assign w_idle_nxt = bus.stop || ((r_state == ST_IDLE) && !bus.start);

  or1200_pad_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_pad_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      (bus.aes_text_out),
    .i_pop       (bus.pad_rd),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_full      (w_full),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_OFB;
      r_discard     <= 1'b0;
      r_aes_ld      <= 1'b0;
      r_aes_text_in <= '0;
      r_work        <= '0;
      r_next        <= '0;
      r_unstall     <= 1'b1;
    end else begin
      r_aes_ld  <= 1'b0;
      r_unstall <= w_idle_nxt || (w_level_nxt != '0);

      if (bus.stop) begin
        r_state   <= ST_IDLE;
        r_discard <= w_inflight;
      end else if (bus.start) begin
        r_mode <= mode_e'(bus.mode);
        r_work <= w_seed;
        r_next <= w_seed;
        if (w_inflight) begin
          // Let the stale op finish; the first new load follows its aes_done.
          r_state   <= ST_WAIT;
          r_discard <= 1'b1;
        end else begin
          // The FIFO has just been flushed, so the ISSUE step always succeeds:
          // fold it into this edge to load the seed one cycle after start.
          r_state       <= ST_WAIT;
          r_discard     <= 1'b0;
          r_aes_ld      <= 1'b1;
          r_aes_text_in <= w_seed;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.aes_done) r_discard <= 1'b0;
          end
          ST_ISSUE: begin
            if (!w_full) begin
              r_aes_ld      <= 1'b1;
              r_aes_text_in <= r_next;
              r_state       <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (bus.aes_done) begin
              r_state   <= ST_ISSUE;
              r_discard <= 1'b0;
              if (!r_discard) begin
                if (r_mode == MODE_CTR) begin
                  r_work <= w_work_inc;
                  r_next <= w_work_inc;
                end else begin
                  r_next <= bus.aes_text_out;
                end
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.aes_ld      = r_aes_ld;
  assign bus.aes_text_in = r_aes_text_in;
  assign bus.pad_out     = w_head;
  assign bus.pad_valid   = w_valid;
  assign bus.pad_level   = w_level;
  assign bus.unstall     = r_unstall;

endmodule
